// File: rtl/vecmac_pkg.sv
// Shared types and tree-geometry helpers for the int8 vector-MAC datapath.
// Keeps the adder tree and its sequencer agreeing on sum width.
package vecmac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic int tree_stages(int lanes);
        return (lanes < 4) ? 2 : $clog2(lanes);
    endfunction

    function automatic int tree_outw(int lanes, int inw);
        return inw + tree_stages(lanes) + 1;
    endfunction

endpackage

// File: rtl/vecmac_seq_ctrl_if.sv
// Command, chunk, tree and result bundle of the vector-MAC sequencer.
// master = integrating side, slave = sequencer.
interface vecmac_seq_ctrl_if
    import vecmac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int INW   = 16,
    parameter int OUTW  = tree_outw(LANES, INW),
    parameter int LENW  = 12,
    parameter int ACCW  = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LENW-1:0]       cmd_len;
    logic                  din_valid;
    logic                  din_ready;
    logic [LANES*INW-1:0]  din_flat;
    logic                  tree_in_valid;
    logic [LANES*INW-1:0]  tree_prod_flat;
    logic                  tree_out_valid;
    logic [OUTW-1:0]       tree_sum;
    logic                  res_valid;
    logic                  res_ready;
    logic [ACCW-1:0]       res_sum;
    logic                  res_ovf;
    logic                  err_spur;

    modport master (
        output cmd_valid, cmd_len, din_valid, din_flat,
        output tree_out_valid, tree_sum, res_ready,
        input  cmd_ready, din_ready, tree_in_valid, tree_prod_flat,
        input  res_valid, res_sum, res_ovf, err_spur
    );

    modport slave (
        input  cmd_valid, cmd_len, din_valid, din_flat,
        input  tree_out_valid, tree_sum, res_ready,
        output cmd_ready, din_ready, tree_in_valid, tree_prod_flat,
        output res_valid, res_sum, res_ovf, err_spur
    );

endinterface

// File: rtl/vecmac_acc.sv
// Job accumulator: clear on job start, add per tree return,
// sticky flag when the sum carries out of ACCW bits.
module vecmac_acc #(
    parameter int ACCW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            add_en,
    input  logic [ACCW-1:0] addend,
    output logic [ACCW-1:0] acc,
    output logic            carry
);
    logic [ACCW:0] sum;

    assign sum = {1'b0, acc} + {1'b0, addend};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (add_en) begin
            acc <= sum[ACCW-1:0];
            if (sum[ACCW]) carry <= 1'b1;
        end
    end

endmodule

// File: rtl/vecmac_seq_ctrl.sv
// Job sequencer for the pipelined adder tree: issues LANES-wide chunks,
// counts returns and hands out one accumulated sum per job.
module vecmac_seq_ctrl
    import vecmac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int INW   = 16,
    parameter int LENW  = 12,
    parameter int ACCW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    vecmac_seq_ctrl_if.slave bus
);
    localparam int STAGES = tree_stages(LANES);
    localparam int OUTW   = INW + STAGES + 1;

    state_t               state, state_nx;
    logic [LENW-1:0]      len_q, iss_cnt, ret_cnt, ret_nx;
    logic                 busy, cmd_acc, accept, ret_ok, spur;
    logic                 din_rdy, cmd_rdy, res_vld;
    logic                 tiv_q, err_q;
    logic [LANES*INW-1:0] prod_q;
    logic [OUTW-1:0]      tsum;
    logic [ACCW-1:0]      acc;
    logic                 ovf;

    assign busy    = (state == ST_RUN) || (state == ST_DRAIN);
    assign cmd_acc = (state == ST_IDLE) && bus.cmd_valid;
    assign accept  = din_rdy && bus.din_valid;
    // A return with nothing outstanding is never trusted as data
    assign ret_ok  = bus.tree_out_valid && busy && (ret_cnt != iss_cnt);
    assign spur    = bus.tree_out_valid && !ret_ok;
    assign ret_nx  = ret_cnt + LENW'(ret_ok);
    assign tsum    = bus.tree_sum;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cmd_rdy  = 1'b0;
        din_rdy  = 1'b0;
        res_vld  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_rdy = 1'b1;
                if (bus.cmd_valid)
                    state_nx = (bus.cmd_len == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                din_rdy = (iss_cnt < len_q);
                if (din_rdy && bus.din_valid &&
                    (iss_cnt + LENW'(1) == len_q))
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (ret_nx == len_q) state_nx = ST_DONE;
            end
            ST_DONE: begin
                res_vld = 1'b1;
                if (bus.res_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            iss_cnt <= '0;
            ret_cnt <= '0;
        end else if (cmd_acc) begin
            len_q   <= bus.cmd_len;
            iss_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (accept) iss_cnt <= iss_cnt + LENW'(1);
            ret_cnt <= ret_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tiv_q  <= 1'b0;
            prod_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tiv_q <= accept;
            if (accept) prod_q <= bus.din_flat;
            if (spur)   err_q  <= 1'b1;
        end
    end

    vecmac_acc #(.ACCW(ACCW)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (cmd_acc),
        .add_en (ret_ok),
        .addend (ACCW'(tsum)),
        .acc    (acc),
        .carry  (ovf)
    );

    assign bus.cmd_ready      = cmd_rdy;
    assign bus.din_ready      = din_rdy;
    assign bus.tree_in_valid  = tiv_q;
    assign bus.tree_prod_flat = prod_q;
    assign bus.res_valid      = res_vld;
    assign bus.res_sum        = acc;
    assign bus.res_ovf        = ovf;
    assign bus.err_spur       = err_q;

endmodule

// File: tb/tb_vecmac_seq_ctrl.sv
// Bench for vecmac_seq_ctrl: two instances (ACCW 32 and 20) with
// behavioural adder trees of different depth.
module tb_vecmac_seq_ctrl;
    import vecmac_pkg::*;

    localparam int OUTW = tree_outw(4, 16);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [11:0] cmd_len = '0;
    logic        din_valid = 1'b0;
    logic [63:0] din_flat = '0;
    logic        res_ready = 1'b0;
    logic        inj0 = 1'b0;

    vecmac_seq_ctrl_if #(.ACCW(32)) bus0 ();
    vecmac_seq_ctrl_if #(.ACCW(20)) bus1 ();

    vecmac_seq_ctrl #(.ACCW(32)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    vecmac_seq_ctrl #(.ACCW(20)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus0.cmd_valid = cmd_valid & ~sel;
    assign bus1.cmd_valid = cmd_valid & sel;
    assign bus0.cmd_len   = cmd_len;
    assign bus1.cmd_len   = cmd_len;
    assign bus0.din_valid = din_valid & ~sel;
    assign bus1.din_valid = din_valid & sel;
    assign bus0.din_flat  = din_flat;
    assign bus1.din_flat  = din_flat;
    assign bus0.res_ready = res_ready & ~sel;
    assign bus1.res_ready = res_ready & sel;

    function automatic logic [OUTW-1:0] lane_sum(logic [63:0] f);
        logic [OUTW-1:0] s = '0;
        for (int i = 0; i < 4; i++) s += OUTW'(f[i*16 +: 16]);
        return s;
    endfunction

    // Tree models: 2-deep for u0, 3-deep for u1
    logic [1:0]      t0_v;
    logic [OUTW-1:0] t0_s [2];
    logic [2:0]      t1_v;
    logic [OUTW-1:0] t1_s [3];

    always @(posedge clk) begin
        if (rst) begin
            t0_v <= '0;
            t1_v <= '0;
        end else begin
            t0_v <= {t0_v[0], bus0.tree_in_valid};
            t1_v <= {t1_v[1:0], bus1.tree_in_valid};
        end
        t0_s[0] <= lane_sum(bus0.tree_prod_flat);
        t0_s[1] <= t0_s[0];
        t1_s[0] <= lane_sum(bus1.tree_prod_flat);
        t1_s[1] <= t1_s[0];
        t1_s[2] <= t1_s[1];
    end

    assign bus0.tree_out_valid = t0_v[1] | inj0;
    assign bus0.tree_sum       = t0_s[1];
    assign bus1.tree_out_valid = t1_v[2];
    assign bus1.tree_sum       = t1_s[2];

    logic        cmd_ready_m, din_ready_m, res_valid_m, res_ovf_m;
    logic        err_spur_m, tiv_m;
    logic [31:0] res_sum_m;

    assign cmd_ready_m = sel ? bus1.cmd_ready : bus0.cmd_ready;
    assign din_ready_m = sel ? bus1.din_ready : bus0.din_ready;
    assign res_valid_m = sel ? bus1.res_valid : bus0.res_valid;
    assign res_ovf_m   = sel ? bus1.res_ovf : bus0.res_ovf;
    assign err_spur_m  = sel ? bus1.err_spur : bus0.err_spur;
    assign tiv_m       = sel ? bus1.tree_in_valid : bus0.tree_in_valid;
    assign res_sum_m   = sel ? 32'(bus1.res_sum) : bus0.res_sum;

    int tiv0 = 0;
    int tiv1 = 0;
    always @(negedge clk) begin
        if (bus0.tree_in_valid) tiv0 <= tiv0 + 1;
        if (bus1.tree_in_valid) tiv1 <= tiv1 + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          sel;
        int          len;
        logic [63:0] flat;
        int          gap;
        int          hold;
        logic [31:0] exp_sum;
        bit          exp_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        bit          ovf;
    } res_t;

    res_t sb[$];
    vec_t vecs[6];

    task automatic run_job(input vec_t v);
        int   k;
        int   sent;
        int   gap_left;
        int   stalls;
        int   guard;
        int   tstart;
        res_t e;
        sel = v.sel;
        k = 0;
        while (!cmd_ready_m && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready_idle", cmd_ready_m, 1);
        tstart = sel ? tiv1 : tiv0;
        cmd_valid = 1'b1;
        cmd_len = 12'(v.len);
        sb.push_back('{sum: v.exp_sum, ovf: v.exp_ovf});
        @(negedge clk);
        cmd_valid = 1'b0;
        if (v.len == 0) chk("len0_res_valid", res_valid_m, 1);
        else            chk("busy_cmd_ready", cmd_ready_m, 0);
        sent = 0;
        gap_left = v.gap;
        stalls = 0;
        guard = 0;
        while (sent < v.len && guard < 500) begin
            if (sent == 1 && gap_left > 0) begin
                din_valid = 1'b0;
                gap_left--;
            end else if (din_ready_m) begin
                din_valid = 1'b1;
                din_flat = v.flat;
                sent++;
            end else begin
                din_valid = 1'b0;
                stalls++;
            end
            @(negedge clk);
            guard++;
        end
        din_valid = 1'b0;
        chk("chunks_sent", sent, v.len);
        if (v.len > 0) begin
            chk("din_stalls", stalls, 0);
            chk("drain_din_ready", din_ready_m, 0);
        end
        k = 0;
        while (!res_valid_m && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("res_valid_seen", res_valid_m, 1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            e = '{sum: '0, ovf: 1'b0};
        end else begin
            e = sb.pop_front();
        end
        chk("res_sum", res_sum_m, e.sum);
        chk("res_ovf", res_ovf_m, e.ovf);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("hold_stable", {res_valid_m, cmd_ready_m, din_ready_m,
                                res_sum_m}, {3'b100, e.sum});
        end
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_len = 12'd1;
        @(negedge clk);
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("idle_after_res", {cmd_ready_m, res_valid_m}, 2'b10);
        chk("issue_count", (sel ? tiv1 : tiv0) - tstart, v.len);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 1, 64'h0001_0001_0001_0001, 0, 0, 32'd4, 0};
        vecs[1] = '{0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 32'd786420, 0};
        vecs[2] = '{0, 0, 64'h0, 0, 2, 32'd0, 0};
        vecs[3] = '{0, 2, 64'h1234_1234_1234_1234, 3, 5, 32'd37280, 0};
        vecs[4] = '{1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 32'd262124, 1};
        vecs[5] = '{0, 1, 64'h0004_0003_0002_0001, 0, 0, 32'd10, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_flags", {cmd_ready_m, din_ready_m, res_valid_m, tiv_m,
                          err_spur_m, res_ovf_m}, 6'b100000);
        chk("rst_res_sum", res_sum_m, 0);
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_job(vecs[i]);
        sel = 1'b0;
        @(negedge clk);

        // Abort a 4-chunk job after two chunks with a one-cycle reset
        cmd_valid = 1'b1;
        cmd_len = 12'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din_valid = 1'b1;
            din_flat = 64'h0100_0100_0100_0100;
            @(negedge clk);
        end
        din_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_flags", {cmd_ready_m, res_valid_m, err_spur_m}, 3'b100);
        @(negedge clk);
        run_job(vecs[5]);

        chk("spur_pre", err_spur_m, 0);
        inj0 = 1'b1;
        @(negedge clk);
        inj0 = 1'b0;
        chk("spur_set", err_spur_m, 1);
        @(negedge clk);
        chk("spur_sticky", err_spur_m, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("spur_rst_clear", err_spur_m, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vecmac_seq_ctrl.md
Name: vecmac_seq_ctrl

Overview:
- Job-level sequencer for the pipelined adder tree (adder_tree_var) in the int8 vector-MAC datapath.
- Accepts a command giving a dot-product length in LANES-wide chunks, streams the chunks from the product stage into the tree, and accumulates each tree sum.
- Counts issued vs. returned chunks and presents one accumulated result per job on a valid/ready port.
- Latency-agnostic: correctness never depends on the tree pipeline depth.

Parameters:
- LANES, 4, lanes per chunk; must match the adder tree instance.
- INW, 16, width of each product lane.
- STAGES, derived, (LANES<4) ? 2 : clog2(LANES).
- OUTW, derived, INW+STAGES+1; width of the tree sum.
- LENW, 12, width of the command length field (chunks).
- ACCW, 32, accumulator/result width; must be >= OUTW.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset; adder tree instance is tied to rst_n = ~rst.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  high only in IDLE.
- cmd_len  in  LENW  number of chunks in the job.
- din_valid  in  1  product chunk valid.
- din_ready  out  1  chunk accepted when valid && ready.
- din_flat  in  LANES*INW  product chunk.
- tree_in_valid  out  1  to tree in_valid.
- tree_prod_flat  out  LANES*INW  to tree prod_flat.
- tree_out_valid  in  1  from tree out_valid.
- tree_sum  in  OUTW  from tree sum; unsigned.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_sum  out  ACCW  accumulated sum, modulo 2^ACCW.
- res_ovf  out  1  sticky: accumulator carried out during this job.
- err_spur  out  1  sticky: tree_out_valid arrived with no chunk in flight; cleared only by rst.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state IDLE; counters, accumulator and length register 0; all outputs 0 except cmd_ready=1. Applies from any state, including mid-job. Data in flight in the tree is flushed by the tree's own reset.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: cmd_ready=1.
  - On cmd_valid: latch cmd_len, clear acc, iss_cnt, ret_cnt and res_ovf.
  - cmd_len=0 -> DONE next cycle with res_sum=0.
  - Otherwise -> RUN.
- RUN: din_ready = (iss_cnt < len).
  - An accepted chunk registers into tree_prod_flat with tree_in_valid=1 in the next cycle, so throughput is 1 chunk/clk.
  - tree_in_valid=0 in any cycle without an accept. tree_prod_flat holds its last value.
  - Accepting the last chunk (iss_cnt becomes len) -> DRAIN.
- DRAIN: din_ready=0. Returns keep accumulating. When ret_cnt reaches len -> DONE.
- Return handling (any of RUN/DRAIN, every tree_out_valid cycle):
  - acc <= acc + zero-extended tree_sum; ret_cnt++.
  - A carry out of ACCW sets res_ovf.
  - If a return and the final issue occur in the same cycle, both counters update.
  - The last return may occur in RUN's successor cycle; the DONE transition is evaluated on the updated ret_cnt.
- DONE: res_valid=1, res_sum=acc held stable.
  - Hold until res_ready=1, then -> IDLE.
  - A new cmd is not accepted in the same cycle as res handshake; earliest accept is the following cycle.
- Result timing: res_valid rises the cycle after the clk edge that absorbed the final return.
- Spurious tree_out_valid in IDLE or DONE, or when ret_cnt == iss_cnt: ignored for accumulation, sets err_spur.
- din_valid gaps in RUN: no issue, no state change. There is no timeout.

Decomposition:
- Shared package vecmac_pkg:
  - state encoding for IDLE/RUN/DRAIN/DONE;
  - STAGES/OUTW derivation function, so the tree and controller never disagree.
- Sub-module vecmac_acc: ACCW accumulator with clear, add-enable and sticky carry flag.
- The FSM, counters and issue register stay in the top module.
- The adder tree is instantiated by the integrating level, not inside this block.

Test Plan (LANES=4, INW=16, tree attached, ACCW=32 unless stated):
- cmd_len=1, chunk = four lanes 0x0001 -> one tree_in_valid pulse; res_valid with res_sum=4, res_ovf=0.
- cmd_len=3, three back-to-back 0xFFFF chunks -> din_ready high 3 consecutive cycles; res_sum=786420 (3x262140); DRAIN entered after the 3rd accept.
- cmd_len=0 -> res_valid the cycle after cmd accept; res_sum=0; tree_in_valid never asserted.
- cmd_len=2 with a 3-cycle din_valid gap, then res_ready held low 5 cycles:
  - res_valid and res_sum stay stable; cmd_ready=0 and din_ready=0 throughout;
  - IDLE one cycle after res_ready.
- ACCW=20, cmd_len=5, all lanes 0xFFFF -> res_ovf=1, res_sum=262124 (1310700 mod 2^20).
- Reset mid-job:
  - rst for one cycle after 2 of 4 chunks -> next cycle: cmd_ready=1, res_valid=0, err_spur=0.
  - Then cmd_len=1 with lanes {1,2,3,4} -> res_sum=10.
  - Separately, forcing tree_out_valid in IDLE -> err_spur=1.
